// File: rtl/arbiter_pkg.sv
// Shared types for the handshake arbiter: the FSM state encoding.
package arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        FILLED      = 2'd1,
        SEND_OUTPUT = 2'd2
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational wrap-around priority search: first set request at or above ptr.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   win,
    output logic               any
);

    always_comb begin
        win = '0;
        any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any && req[idx]) begin
                win = IDX_W'(idx);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/handshake_arbiter.sv
// Round-robin N:1 handshake arbiter: accept one word, hold it, emit a one-cycle strobe.
module handshake_arbiter
    import arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
    input  logic [NUM_REQ-1:0]            i_valid,
    output logic [NUM_REQ-1:0]            ready_for_input,
    input  logic                          ready_for_output,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_valid,
    output logic [IDX_W-1:0]              o_src
);

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        ptr;
    logic [IDX_W-1:0]        win;
    logic                    any;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   cap_data;
    logic [IDX_W-1:0]        cap_src;

    function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] w);
        if (w == IDX_W'(NUM_REQ - 1)) return '0;
        return w + 1'b1;
    endfunction

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req (i_valid),
        .ptr (ptr),
        .win (win),
        .any (any)
    );

    // Outputs and the accept strobe are forced inactive while reset is high.
    always_comb begin
        state_nxt       = state;
        accept          = 1'b0;
        ready_for_input = '0;
        o_valid         = 1'b0;
        o_data          = '0;
        o_src           = '0;
        case (state)
            IDLE: begin
                if (any && !reset) begin
                    ready_for_input[win] = 1'b1;
                    accept               = 1'b1;
                    state_nxt            = FILLED;
                end
            end
            FILLED: begin
                if (ready_for_output) state_nxt = SEND_OUTPUT;
            end
            SEND_OUTPUT: begin
                if (!reset) begin
                    o_valid = 1'b1;
                    o_data  = cap_data;
                    o_src   = cap_src;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset)       ptr <= '0;
        else if (accept) ptr <= ptr_after(win);
    end

    always_ff @(posedge clk) begin
        if (reset)       cap_data <= '0;
        else if (accept) cap_data <= i_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset)       cap_src <= '0;
        else if (accept) cap_src <= win;
    end

endmodule
